// File: rtl/fsm_meter.sv
// fsm_meter: taximeter trip FSM (IDLE/MOVE/WAIT/STOP) with distance and waiting-time tick generators.
// Optional key debouncing is enabled by defining FSM_DEBOUNCE_EN. Rev 1.0
`default_nettype none

module fsm_meter #(
    parameter int DEB_CYCLES  = 20,
    parameter int DIST_DIV    = 1000,
    parameter int WAIT_GRACE  = 5000,
    parameter int WAIT_DIV    = 60000,
    parameter int STOP_CYCLES = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_1,
    input  logic       key_2,
    output logic [1:0] state,
    output logic       dist_tick,
    output logic       wait_tick,
    output logic       trip_start,
    output logic       trip_end
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MOVE = 2'b01,
        S_WAIT = 2'b11,
        S_STOP = 2'b10
    } state_t;

    localparam int DW = (DIST_DIV > 1)    ? $clog2(DIST_DIV)       : 1;
    localparam int GW = (WAIT_GRACE > 0)  ? $clog2(WAIT_GRACE + 1) : 1;
    localparam int PW = (WAIT_DIV > 1)    ? $clog2(WAIT_DIV)       : 1;
    localparam int SW = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES)    : 1;

    localparam logic [DW-1:0] c_dist_max = DW'(DIST_DIV - 1);
    localparam logic [GW-1:0] c_grace    = GW'(WAIT_GRACE);
    localparam logic [PW-1:0] c_wait_max = PW'(WAIT_DIV - 1);
    localparam logic [SW-1:0] c_stop_max = SW'(STOP_CYCLES - 1);

    generate
        if (DEB_CYCLES < 1 || DEB_CYCLES > 65535 || DIST_DIV < 2 || DIST_DIV > 65535 ||
            WAIT_GRACE < 0 || WAIT_GRACE > 65535 || WAIT_DIV < 2 || WAIT_DIV > 65535 ||
            STOP_CYCLES < 1 || STOP_CYCLES > 65535) begin : g_param_err
            $error("fsm_meter: parameter out of legal range");
        end
    endgenerate

    // Bit 0 carries key_1, bit 1 carries key_2
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] w_k;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {key_2, key_1};
            r_sync2 <= r_sync1;
        end
    end

`ifdef FSM_DEBOUNCE_EN
    localparam int DBW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DBW-1:0] c_deb_max = DBW'(DEB_CYCLES - 1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            logic           r_kq;
            logic [DBW-1:0] r_cnt;

            // Any sample equal to the accepted value restarts the stability run
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_kq  <= 1'b0;
                    r_cnt <= '0;
                end else if (r_sync2[gi] == r_kq) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_deb_max) begin
                    r_kq  <= r_sync2[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DBW'(1);
                end
            end

            assign w_k[gi] = r_kq;
        end
    endgenerate
`else
    assign w_k = r_sync2;
`endif

    state_t         r_state;
    state_t         w_next;
    logic [SW-1:0]  r_stop;
    logic [DW-1:0]  r_dist;
    logic [GW-1:0]  r_grace;
    logic [PW-1:0]  r_period;
    logic [GW-1:0]  w_grace_base;
    logic [PW-1:0]  w_period_base;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_k[0] && w_k[1])  w_next = S_MOVE;
                else if (w_k[0])       w_next = S_WAIT;
            end
            S_MOVE: begin
                if (!w_k[0])           w_next = S_STOP;
                else if (!w_k[1])      w_next = S_WAIT;
            end
            S_WAIT: begin
                if (!w_k[0])           w_next = S_STOP;
                else if (w_k[1])       w_next = S_MOVE;
            end
            S_STOP: begin
                if (r_stop == c_stop_max) w_next = S_IDLE;
            end
            default:                   w_next = S_IDLE;
        endcase
    end

    // Wait counters restart from zero on every fresh WAIT entry
    assign w_grace_base  = (r_state == S_WAIT) ? r_grace  : '0;
    assign w_period_base = (r_state == S_WAIT) ? r_period : '0;

    // Counters and pulses are driven from the next state so every registered
    // output lines up with the cycle in which that state is visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_stop     <= '0;
            r_dist     <= '0;
            r_grace    <= '0;
            r_period   <= '0;
            dist_tick  <= 1'b0;
            wait_tick  <= 1'b0;
            trip_start <= 1'b0;
            trip_end   <= 1'b0;
        end else begin
            r_state    <= w_next;
            trip_start <= (r_state == S_IDLE) && (w_next != S_IDLE);
            trip_end   <= (w_next == S_STOP) && (r_state != S_STOP);
            dist_tick  <= 1'b0;
            wait_tick  <= 1'b0;

            if ((w_next == S_STOP) && (r_state == S_STOP)) r_stop <= r_stop + SW'(1);
            else                                             r_stop <= '0;

            if (w_next == S_MOVE) begin
                if (r_dist == c_dist_max) begin
                    r_dist    <= '0;
                    dist_tick <= 1'b1;
                end else begin
                    r_dist <= r_dist + DW'(1);
                end
            end else if (w_next != S_WAIT) begin
                r_dist <= '0;
            end

            if (w_next == S_WAIT) begin
                if (w_grace_base != c_grace) begin
                    r_grace  <= w_grace_base + GW'(1);
                    r_period <= '0;
                end else if (w_period_base == c_wait_max) begin
                    r_grace   <= w_grace_base;
                    r_period  <= '0;
                    wait_tick <= 1'b1;
                end else begin
                    r_grace  <= w_grace_base;
                    r_period <= w_period_base + PW'(1);
                end
            end else begin
                r_grace  <= '0;
                r_period <= '0;
            end
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_fsm_meter.sv
// tb_fsm_meter: table vectors, directed trip sequences and random keys against a count-based reference model.
`default_nettype none

module tb_fsm_meter;

    localparam int P_DEB   = 4;
    localparam int P_DIST  = 10;
    localparam int P_GRACE = 5;
    localparam int P_WDIV  = 8;
    localparam int P_STOP  = 6;
`ifdef FSM_DEBOUNCE_EN
    localparam int LAT    = P_DEB + 3;
    localparam int DEB_ON = 1;
`else
    localparam int LAT    = 3;
    localparam int DEB_ON = 0;
`endif

    localparam int ST_IDLE = 0;
    localparam int ST_MOVE = 1;
    localparam int ST_WAIT = 3;
    localparam int ST_STOP = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_1 = 1'b0;
    logic       key_2 = 1'b0;
    logic [1:0] state;
    logic       dist_tick, wait_tick, trip_start, trip_end;

    always #5 clk = ~clk;

    fsm_meter #(
        .DEB_CYCLES (P_DEB),
        .DIST_DIV   (P_DIST),
        .WAIT_GRACE (P_GRACE),
        .WAIT_DIV   (P_WDIV),
        .STOP_CYCLES(P_STOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_1     (key_1),
        .key_2     (key_2),
        .state     (state),
        .dist_tick (dist_tick),
        .wait_tick (wait_tick),
        .trip_start(trip_start),
        .trip_end  (trip_end)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: key history per edge plus plain cycle counts per state
    bit h1 [0:8191];
    bit h2 [0:8191];
    int n = 16;
    int ms = ST_IDLE;
    bit mk1 = 0, mk2 = 0;
    int move_cnt = 0, wait_n = 0, stop_n = 0;
    bit mdt = 0, mwt = 0, mts = 0, mte = 0;

    task automatic model_edge(input bit r, input bit a, input bit b);
        int  ns;
        int  base;
        bit  all1, all2;
        n++;
        h1[n] = a;
        h2[n] = b;
        if (!r) begin
            for (int i = n - P_DEB - 3; i <= n; i++) begin
                h1[i] = 1'b0;
                h2[i] = 1'b0;
            end
            ms = ST_IDLE; mk1 = 0; mk2 = 0;
            move_cnt = 0; wait_n = 0; stop_n = 0;
            mdt = 0; mwt = 0; mts = 0; mte = 0;
        end else begin
            ns = ms;
            case (ms)
                ST_IDLE: if (mk1 && mk2) ns = ST_MOVE; else if (mk1) ns = ST_WAIT;
                ST_MOVE: if (!mk1) ns = ST_STOP; else if (!mk2) ns = ST_WAIT;
                ST_WAIT: if (!mk1) ns = ST_STOP; else if (mk2) ns = ST_MOVE;
                default: if (stop_n >= P_STOP) ns = ST_IDLE;
            endcase
            mts = (ms == ST_IDLE) && (ns != ST_IDLE);
            mte = (ns == ST_STOP) && (ms != ST_STOP);
            stop_n = (ns == ST_STOP) ? ((ms == ST_STOP) ? stop_n + 1 : 1) : 0;
            mdt = 0;
            if (ns == ST_MOVE) begin
                move_cnt++;
                mdt = (move_cnt % P_DIST) == 0;
            end else if (ns != ST_WAIT) begin
                move_cnt = 0;
            end
            mwt = 0;
            if (ns == ST_WAIT) begin
                wait_n = (ms == ST_WAIT) ? wait_n + 1 : 1;
                mwt = (wait_n > P_GRACE) && (((wait_n - P_GRACE) % P_WDIV) == 0);
            end else begin
                wait_n = 0;
            end
            ms = ns;
            if (DEB_ON != 0) begin
                base = n - 1 - P_DEB;
                all1 = 1; all2 = 1;
                for (int i = base + 1; i <= n - 2; i++) begin
                    if (h1[i] != h1[base]) all1 = 0;
                    if (h2[i] != h2[base]) all2 = 0;
                end
                if (all1) mk1 = h1[n - 2];
                if (all2) mk2 = h2[n - 2];
            end else begin
                mk1 = h1[n - 1];
                mk2 = h2[n - 1];
            end
        end
    endtask

    task automatic step(input bit r, input bit a, input bit b);
        @(negedge clk);
        rst_n = r;
        key_1 = a;
        key_2 = b;
        @(posedge clk);
        model_edge(r, a, b);
        #1;
        chk("model", int'({state, dist_tick, wait_tick, trip_start, trip_end}),
            ms * 16 + int'(mdt) * 8 + int'(mwt) * 4 + int'(mts) * 2 + int'(mte));
    endtask

    typedef struct {
        bit rst;
        bit k1;
        bit k2;
        int cyc;
        int st;
        int n_ts;
        int n_te;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ts_c, te_c, cnt, pos, first, saw;
        bit tg, ra, rb;
        int rl;

        tbl[0] = '{rst:0, k1:0, k2:0, cyc:3,  st:ST_IDLE, n_ts:0, n_te:0};
        tbl[1] = '{rst:1, k1:1, k2:1, cyc:12, st:ST_MOVE, n_ts:1, n_te:0};
        tbl[2] = '{rst:1, k1:1, k2:0, cyc:12, st:ST_WAIT, n_ts:0, n_te:0};
        tbl[3] = '{rst:1, k1:1, k2:1, cyc:12, st:ST_MOVE, n_ts:0, n_te:0};
        tbl[4] = '{rst:1, k1:0, k2:1, cyc:8,  st:ST_STOP, n_ts:0, n_te:1};
        tbl[5] = '{rst:1, k1:0, k2:1, cyc:10, st:ST_IDLE, n_ts:0, n_te:0};
        tbl[6] = '{rst:1, k1:1, k2:0, cyc:12, st:ST_WAIT, n_ts:1, n_te:0};
        tbl[7] = '{rst:0, k1:1, k2:0, cyc:1,  st:ST_IDLE, n_ts:0, n_te:0};
        tbl[8] = '{rst:1, k1:0, k2:0, cyc:12, st:ST_IDLE, n_ts:0, n_te:0};
        tbl[9] = '{rst:1, k1:1, k2:0, cyc:12, st:ST_WAIT, n_ts:1, n_te:0};

        repeat (2) step(0, 0, 0);
        chk("reset_state", int'(state), ST_IDLE);
        chk("reset_outputs", int'({dist_tick, wait_tick, trip_start, trip_end}), 0);

        for (int v = 0; v < 10; v++) begin
            ts_c = 0;
            te_c = 0;
            for (int c = 0; c < tbl[v].cyc; c++) begin
                step(tbl[v].rst, tbl[v].k1, tbl[v].k2);
                ts_c += int'(trip_start);
                te_c += int'(trip_end);
            end
            chk($sformatf("tbl%0d_state", v), int'(state), tbl[v].st);
            chk($sformatf("tbl%0d_trip_start", v), ts_c, tbl[v].n_ts);
            chk($sformatf("tbl%0d_trip_end", v), te_c, tbl[v].n_te);
        end

        // Start-up latency, MOVE 7 / WAIT 20 / MOVE with tick placement
        repeat (2) step(0, 0, 0);
        cnt = 0;
        do begin step(1, 1, 1); cnt++; end while (state != 2'(ST_MOVE) && cnt < 20);
        chk("move_latency", cnt, LAT);
        chk("trip_start_on_move", int'(trip_start), 1);
        cnt = 1; saw = 0;
        repeat (7 - LAT) begin
            step(1, 1, 1);
            if (state == 2'(ST_MOVE)) cnt++;
            saw += int'(dist_tick);
        end
        rl = 0;
        while (rl < 20) begin
            step(1, 1, 0);
            rl++;
            if (state != 2'(ST_MOVE)) break;
            cnt++;
            saw += int'(dist_tick);
        end
        chk("move_cycles", cnt, 7);
        chk("early_dist_ticks", saw, 0);
        chk("wait_entered", int'(state), ST_WAIT);
        cnt = 1; saw = 0; first = 0;
        repeat (20 - LAT) begin
            step(1, 1, 0);
            if (state == 2'(ST_WAIT)) cnt++;
            if (wait_tick) begin saw++; if (first == 0) first = cnt; end
        end
        rl = 0;
        while (rl < 20) begin
            step(1, 1, 1);
            rl++;
            if (state != 2'(ST_WAIT)) break;
            cnt++;
            if (wait_tick) begin saw++; if (first == 0) first = cnt; end
        end
        chk("wait_cycles", cnt, 20);
        chk("wait_tick_count", saw, 1);
        chk("wait_tick_pos", first, 13);
        pos = 1; first = 0;
        while (!dist_tick && pos < 20) begin step(1, 1, 1); pos++; end
        chk("dist_after_return", pos, 3);
        cnt = 0;
        do begin step(1, 1, 1); cnt++; end while (!dist_tick && cnt < 30);
        chk("dist_period", cnt, P_DIST);

        // Trip end from WAIT, STOP held with key_1 toggling
        cnt = 0;
        do begin step(1, 1, 0); cnt++; end while (state != 2'(ST_WAIT) && cnt < 20);
        cnt = 0;
        do begin step(1, 0, 0); cnt++; end while (state != 2'(ST_STOP) && cnt < 20);
        chk("stop_entered", int'(state), ST_STOP);
        chk("trip_end_pulse", int'(trip_end), 1);
        cnt = 1; tg = 1'b1; rl = 0;
        while (rl < 20) begin
            step(1, tg, 0);
            tg = ~tg;
            rl++;
            if (state != 2'(ST_STOP)) break;
            cnt++;
        end
        chk("stop_cycles", cnt, P_STOP);
        chk("after_stop_idle", int'(state), ST_IDLE);
        repeat (12) step(1, 0, 0);

        // Two-cycle key_2 glitch while moving
        cnt = 0;
        do begin step(1, 1, 1); cnt++; end while (state != 2'(ST_MOVE) && cnt < 20);
        repeat (4) step(1, 1, 1);
        saw = 0;
        repeat (2) begin step(1, 1, 0); if (state == 2'(ST_WAIT)) saw = 1; end
        repeat (15) begin step(1, 1, 1); if (state == 2'(ST_WAIT)) saw = 1; end
        chk("glitch_wait_seen", saw, (DEB_ON != 0) ? 0 : 1);
        chk("glitch_final_move", int'(state), ST_MOVE);

        // One-cycle reset mid-trip
        step(0, 1, 1);
        chk("midtrip_reset_state", int'(state), ST_IDLE);
        chk("midtrip_reset_outs", int'({dist_tick, wait_tick, trip_start, trip_end}), 0);
        repeat (3) step(1, 0, 0);

        // Random key activity with occasional resets
        repeat (160) begin
            ra = ($urandom_range(0, 3) != 0);
            rb = $urandom_range(0, 1) != 0;
            rl = $urandom_range(1, 25);
            if ($urandom_range(0, 40) == 0) step(0, ra, rb);
            repeat (rl) step(1, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fsm_meter.md
FSM_METER -- requirements
Module: fsm_meter

Interface
REQ-001 Parameter DEB_CYCLES, default 20: consecutive stable cycles required to accept a key change (FSM_DEBOUNCE_EN only); legal range 1..65535.
REQ-002 Parameter DIST_DIV, default 1000: MOVE cycles per dist_tick; legal range 2..65535.
REQ-003 Parameter WAIT_GRACE, default 5000: WAIT cycles before the first wait_tick period may start; legal range 0..65535.
REQ-004 Parameter WAIT_DIV, default 60000: WAIT cycles per wait_tick after grace; legal range 2..65535.
REQ-005 Parameter STOP_CYCLES, default 3000: cycles held in STOP after trip end; legal range 1..65535.
REQ-006 clk  input  1  clock, 1 kHz nominal, all logic on posedge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 key_1  input  1  carriage status, asynchronous (1 = occupied, 0 = vacant).
REQ-009 key_2  input  1  driving status, asynchronous (1 = moving, 0 = waiting).
REQ-010 state  output  2  current state: IDLE=2'b00, MOVE=2'b01, WAIT=2'b11, STOP=2'b10.
REQ-011 dist_tick  output  1  one-cycle pulse per DIST_DIV MOVE cycles.
REQ-012 wait_tick  output  1  one-cycle pulse per WAIT_DIV chargeable WAIT cycles.
REQ-013 trip_start  output  1  one-cycle pulse on leaving IDLE.
REQ-014 trip_end  output  1  one-cycle pulse on entering STOP.

Function
REQ-015 key_1/key_2 SHALL pass a 2-flop synchronizer; the FSM acts only on the qualified copies k1/k2.
REQ-016 Transitions (evaluated every edge on k1/k2): IDLE: k1&k2->MOVE, k1&!k2->WAIT, else hold; MOVE: !k1->STOP, !k2->WAIT, else hold; WAIT: !k1->STOP, k2->MOVE, else hold; STOP: hold until its counter expires, then IDLE.
REQ-017 In STOP, keys SHALL be ignored; on the expiry edge state SHALL go to IDLE regardless of k1, and the IDLE rules apply from the next edge.
REQ-018 STOP duration SHALL be exactly STOP_CYCLES cycles, counted from the entry edge.
REQ-019 Distance counter: SHALL increment every cycle in MOVE; at value DIST_DIV-1, assert dist_tick that cycle and wrap to 0; hold in WAIT (fraction retained); clear in IDLE and STOP.
REQ-020 Wait logic: on WAIT entry, grace and period counters SHALL clear; no wait_tick during the first WAIT_GRACE cycles; afterwards wait_tick every WAIT_DIV cycles; leaving WAIT SHALL clear both counters.
REQ-021 Outputs SHALL be registered; dist_tick and wait_tick SHALL never both be high; trip_start/trip_end SHALL assert in the cycle the new state is first visible.
REQ-022 Illegal state values SHALL recover to IDLE on the next edge.
REQ-023 Counters SHALL be sized by $clog2 of their parameter and SHALL never overflow.

Reset
REQ-024 While rst_n=0 at an edge: state=IDLE, all ticks/pulses 0, all counters and synchronizer/debounce registers 0.
REQ-025 Reset asserted mid-trip (any state) SHALL take effect at that edge with no trip_end pulse.
REQ-026 After reset release, the first transition SHALL occur only after full synchronizer (and debounce) latency.

Configuration
REQ-027 Macro FSM_DEBOUNCE_EN defined: k1/k2 SHALL update only after the synchronized key holds a new value for DEB_CYCLES consecutive cycles; a glitch shorter than this SHALL be rejected; key change to state change latency = DEB_CYCLES+3 edges.
REQ-028 Macro FSM_DEBOUNCE_EN undefined: k1/k2 SHALL be the synchronizer outputs directly; latency = 3 edges; DEB_CYCLES SHALL be unused.

Verification (DEB_CYCLES=4, DIST_DIV=10, WAIT_GRACE=5, WAIT_DIV=8, STOP_CYCLES=6)
REQ-029 Reset, then key_1=1,key_2=1 -> state=MOVE 7 edges later (3 without FSM_DEBOUNCE_EN), trip_start high 1 cycle, dist_tick every 10th cycle.
REQ-030 MOVE for 7 cycles, WAIT for 20 cycles, MOVE again -> first dist_tick 3 MOVE cycles after return; wait_tick at WAIT cycles 13 and 21 only if WAIT still held (none here before cycle 13? exactly one at cycle 13).
REQ-031 key_1 1->0 during WAIT -> STOP with trip_end pulse, held 6 cycles with key_1 toggled, then IDLE.
REQ-032 2-cycle key_2 glitch in MOVE with FSM_DEBOUNCE_EN -> state stays MOVE; without macro -> WAIT then MOVE.
REQ-033 rst_n=0 for 1 cycle during MOVE -> next state IDLE, all outputs 0, no trip_end.
